// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
package uart_rx_pkg;

  localparam int DATA_W     = 8;
  localparam int PRESCALE_W = 6;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE
  } rx_state_t;

  // Parity bit a transmitter would append for the given data and parity type.
  function automatic logic parity_bit(input logic [DATA_W-1:0] data, input logic typ);
    return (typ == PAR_EVEN) ? ^data : ~^data;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter with three mid-bit samples and a 2-of-3 majority vote.
module uart_rx_sampler
  import uart_rx_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  rx,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  sample_valid,
  output logic                  sampled_bit,
  output logic                  bit_end
);

  logic [PRESCALE_W-1:0] edge_cnt;
  logic [PRESCALE_W-1:0] mid;
  logic                  s0;
  logic                  s1;

  assign mid     = prescale >> 1;
  assign bit_end = enable && (edge_cnt == prescale - 6'd1);

  // The vote is registered, so sampled_bit holds until the next bit's third sample.
  always_ff @(posedge clk) begin
    if (!rst) begin
      edge_cnt     <= '0;
      s0           <= 1'b0;
      s1           <= 1'b0;
      sample_valid <= 1'b0;
      sampled_bit  <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (!enable || bit_end) begin
        edge_cnt <= '0;
      end else begin
        edge_cnt <= edge_cnt + 6'd1;
      end
      if (enable) begin
        if (edge_cnt == mid - 6'd1) begin
          s0 <= rx;
        end
        if (edge_cnt == mid) begin
          s1 <= rx;
        end
        if (edge_cnt == mid + 6'd1) begin
          sampled_bit  <= (s0 & s1) | (s0 & rx) | (s1 & rx);
          sample_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receive front end: deframes start, 8 data bits, optional parity and stop.
module uart_receiver
  import uart_rx_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic [DATA_W-1:0]     P_DATA,
  output logic                  data_valid,
  output logic                  Parity_Error,
  output logic                  Stop_Error
);

  rx_state_t             state;
  rx_state_t             next_state;
  logic                  sample_valid;
  logic                  sampled_bit;
  logic                  bit_end;
  logic                  sample_en;
  logic                  frame_start;
  logic                  shift_en;
  logic                  par_chk;
  logic                  stop_chk;
  logic                  frame_done;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic [PRESCALE_W-1:0] prescale_q;
  logic [2:0]            bit_cnt;
  logic [DATA_W-1:0]     shift_reg;

  uart_rx_sampler u_sampler (
    .clk          (CLK),
    .rst          (RST),
    .enable       (sample_en),
    .rx           (RX_IN),
    .prescale     (prescale_q),
    .sample_valid (sample_valid),
    .sampled_bit  (sampled_bit),
    .bit_end      (bit_end)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // STOP leaves on the vote rather than the bit end so back-to-back frames resync.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!RX_IN) next_state = START;
      START:   if (bit_end) next_state = sampled_bit ? IDLE : DATA;
      DATA:    if (bit_end && bit_cnt == 3'd7) next_state = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_end) next_state = STOP;
      STOP:    if (sample_valid) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    frame_start = 1'b0;
    sample_en   = 1'b0;
    shift_en    = 1'b0;
    par_chk     = 1'b0;
    stop_chk    = 1'b0;
    frame_done  = 1'b0;
    case (state)
      IDLE:    frame_start = !RX_IN;
      START:   sample_en = 1'b1;
      DATA: begin
        sample_en = 1'b1;
        shift_en  = sample_valid;
      end
      PARITY: begin
        sample_en = 1'b1;
        par_chk   = sample_valid;
      end
      STOP: begin
        sample_en = 1'b1;
        stop_chk  = sample_valid;
      end
      DONE:    frame_done = 1'b1;
      default: frame_start = 1'b0;
    endcase
  end

  // Configuration is frozen at frame start; error flags hold until the next frame.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      par_en_q     <= 1'b0;
      par_typ_q    <= PAR_EVEN;
      prescale_q   <= 6'd8;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      P_DATA       <= '0;
      data_valid   <= 1'b0;
      Parity_Error <= 1'b0;
      Stop_Error   <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (frame_start) begin
        par_en_q     <= PAR_EN;
        par_typ_q    <= PAR_TYP;
        prescale_q   <= Prescale;
        Parity_Error <= 1'b0;
        Stop_Error   <= 1'b0;
      end
      if (state != DATA) begin
        bit_cnt <= '0;
      end else if (bit_end) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (shift_en) begin
        shift_reg <= {sampled_bit, shift_reg[DATA_W-1:1]};
      end
      if (par_chk && (sampled_bit != parity_bit(shift_reg, par_typ_q))) begin
        Parity_Error <= 1'b1;
      end
      if (stop_chk && !sampled_bit) begin
        Stop_Error <= 1'b1;
      end
      if (frame_done && !Parity_Error && !Stop_Error) begin
        P_DATA     <= shift_reg;
        data_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: frames are driven bit by bit and good bytes
// are queued, then matched against each data_valid strobe.
module tb_uart_receiver;
  import uart_rx_pkg::*;

  logic       CLK;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       Parity_Error;
  logic       Stop_Error;

  int         total = 0;
  int         bad = 0;
  int         validSeen = 0;
  int         validExp = 0;
  logic [7:0] expData;
  logic [7:0] expQ[$];

  uart_receiver dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_IN        (RX_IN),
    .PAR_EN       (PAR_EN),
    .PAR_TYP      (PAR_TYP),
    .Prescale     (Prescale),
    .P_DATA       (P_DATA),
    .data_valid   (data_valid),
    .Parity_Error (Parity_Error),
    .Stop_Error   (Stop_Error)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic sendBit(input logic b, input int presc);
    RX_IN = b;
    repeat (presc) @(negedge CLK);
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic parEn, input logic parTyp,
                               input logic parGood, input logic stopBit, input int presc);
    logic pb;
    pb = (parTyp == PAR_ODD) ? ~^data : ^data;
    if (!parGood) pb = ~pb;
    PAR_EN   = parEn;
    PAR_TYP  = parTyp;
    Prescale = 6'(presc);
    if (stopBit && (!parEn || parGood)) begin
      expQ.push_back(data);
      expData = data;
      validExp++;
    end
    sendBit(1'b0, presc);
    for (int i = 0; i < 8; i++) sendBit(data[i], presc);
    if (parEn) sendBit(pb, presc);
    sendBit(stopBit, presc);
  endtask

  task automatic checkFrame(input string stage, input logic expPe, input logic expSe);
    RX_IN = 1'b1;
    repeat (6) @(negedge CLK);
    checkOutput({stage, ".parity_err"}, 32'(Parity_Error), 32'(expPe));
    checkOutput({stage, ".stop_err"}, 32'(Stop_Error), 32'(expSe));
    checkOutput({stage, ".p_data"}, 32'(P_DATA), 32'(expData));
    checkOutput({stage, ".valid_count"}, validSeen, validExp);
  endtask

  // Every strobe must match the oldest queued byte.
  always @(negedge CLK) begin
    if (RST === 1'b1 && data_valid === 1'b1) begin
      validSeen++;
      if (expQ.size() == 0) begin
        checkOutput("spurious_valid", 32'(P_DATA), 32'hFFFF_FFFF);
      end else begin
        checkOutput("rx_byte", 32'(P_DATA), 32'(expQ.pop_front()));
      end
    end
  end

  initial begin
    int pList[3];
    logic pbWrong;
    pList    = '{8, 16, 32};
    RST      = 1'b0;
    RX_IN    = 1'b1;
    PAR_EN   = 1'b0;
    PAR_TYP  = PAR_EVEN;
    Prescale = 6'd8;
    expData  = 8'h00;
    repeat (3) @(negedge CLK);
    checkOutput("rst.p_data", 32'(P_DATA), 32'h00);
    checkOutput("rst.valid", 32'(data_valid), 32'h0);
    checkOutput("rst.parity_err", 32'(Parity_Error), 32'h0);
    checkOutput("rst.stop_err", 32'(Stop_Error), 32'h0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'hB2, 1'b0, PAR_EVEN, 1'b1, 1'b1, pList[i]);
      checkFrame($sformatf("nopar_p%0d", pList[i]), 1'b0, 1'b0);
    end
    applyStimulus(8'h01, 1'b0, PAR_EVEN, 1'b1, 1'b1, 16);
    checkFrame("nopar_01", 1'b0, 1'b0);
    applyStimulus(8'h80, 1'b0, PAR_EVEN, 1'b1, 1'b1, 32);
    checkFrame("nopar_80", 1'b0, 1'b0);

    applyStimulus(8'hB2, 1'b1, PAR_EVEN, 1'b1, 1'b1, 8);
    checkFrame("par_even_ok", 1'b0, 1'b0);
    applyStimulus(8'hB2, 1'b1, PAR_ODD, 1'b1, 1'b1, 16);
    checkFrame("par_odd_ok", 1'b0, 1'b0);

    applyStimulus(8'h5C, 1'b0, PAR_EVEN, 1'b1, 1'b1, 8);
    checkFrame("pre_bad", 1'b0, 1'b0);
    applyStimulus(8'hB2, 1'b1, PAR_EVEN, 1'b0, 1'b1, 8);
    checkFrame("par_even_bad", 1'b1, 1'b0);
    applyStimulus(8'hB2, 1'b1, PAR_ODD, 1'b0, 1'b1, 16);
    checkFrame("par_odd_bad", 1'b1, 1'b0);
    applyStimulus(8'hB2, 1'b0, PAR_EVEN, 1'b1, 1'b0, 8);
    checkFrame("stop_bad", 1'b0, 1'b1);

    // Reset while the receiver sits in STOP after flagging a parity error.
    PAR_EN   = 1'b1;
    PAR_TYP  = PAR_EVEN;
    Prescale = 6'd16;
    pbWrong  = ~(^8'h3C);
    sendBit(1'b0, 16);
    for (int i = 0; i < 8; i++) sendBit(i[1:0] inside {2'd2, 2'd3}, 16);
    sendBit(pbWrong, 16);
    RX_IN = 1'b1;
    checkOutput("midrst.pre_parity_err", 32'(Parity_Error), 32'h1);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    expData = 8'h00;
    checkOutput("midrst.p_data", 32'(P_DATA), 32'h00);
    checkOutput("midrst.valid", 32'(data_valid), 32'h0);
    checkOutput("midrst.parity_err", 32'(Parity_Error), 32'h0);
    checkOutput("midrst.stop_err", 32'(Stop_Error), 32'h0);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    applyStimulus(8'hB2, 1'b0, PAR_EVEN, 1'b1, 1'b1, 8);
    checkFrame("post_rst", 1'b0, 1'b0);

    Prescale = 6'd8;
    sendBit(1'b0, 2);
    sendBit(1'b1, 20);
    checkFrame("glitch", 1'b0, 1'b0);

    applyStimulus(8'hB2, 1'b1, PAR_EVEN, 1'b1, 1'b1, 8);
    applyStimulus(8'hA4, 1'b1, PAR_EVEN, 1'b1, 1'b1, 8);
    checkFrame("b2b_even", 1'b0, 1'b0);
    applyStimulus(8'hB2, 1'b1, PAR_ODD, 1'b1, 1'b1, 16);
    applyStimulus(8'hA4, 1'b1, PAR_ODD, 1'b1, 1'b1, 16);
    checkFrame("b2b_odd", 1'b0, 1'b0);
    applyStimulus(8'hB2, 1'b1, PAR_EVEN, 1'b1, 1'b1, 8);
    applyStimulus(8'hA4, 1'b1, PAR_EVEN, 1'b0, 1'b1, 8);
    checkFrame("b2b_badpar", 1'b1, 1'b0);

    checkOutput("pending_exp", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Asynchronous serial (UART) receive front end. Oversamples the `RX_IN` line at `Prescale` clocks per bit. Majority-votes each bit and deframes start, 8 data bits (LSB first), optional parity and stop bit. Presents the byte on `P_DATA` with a one-cycle `data_valid` strobe. Sits between the pad/synchronizer and the byte consumer in the UART subsystem.

## Interface
- No parameters. Data width is fixed at 8, and the counter width is fixed at 6.
- Clock and reset: one clock; reset is synchronous and active-low.
- `CLK` input 1: receive oversampling clock.
- `RST` input 1: synchronous, active-low reset.
- `RX_IN` input 1: serial line; idle = 1; assumed already synchronized.
- `PAR_EN` input 1: 1 = a parity bit follows the data.
- `PAR_TYP` input 1: 0 = even, 1 = odd.
- `Prescale` input 6: oversampling ratio; supported values 8, 16, 32.
- `P_DATA` output 8: last received byte.
- `data_valid` output 1: one-cycle strobe for an error-free frame.
- `Parity_Error` output 1: parity mismatch on the current/last frame.
- `Stop_Error` output 1: stop bit sampled as 0.

## Operation
- States: IDLE, START, DATA, PARITY, STOP, DONE.
- **IDLE**
  - `RX_IN` = 0 → START, edge counter = 0.
  - On leaving IDLE, clear `Parity_Error` and `Stop_Error`, and latch `PAR_EN`, `PAR_TYP` and `Prescale`. Config changes mid-frame have no effect.
- **Edge counter**
  - Counts 0..Prescale−1 within each bit.
  - Samples `RX_IN` at counts P/2−1, P/2 and P/2+1; the bit value is the 2-of-3 majority.
  - The bit counter advances when the edge counter wraps.
- **START**
  - If the voted start bit = 1 (glitch), return to IDLE at the bit end with no outputs changed.
  - Otherwise go to DATA at the bit end.
- **DATA**
  - 8 bits, shifted LSB first into the shift register.
  - After bit 7: go to PARITY if `PAR_EN`, else STOP.
- **PARITY**
  - Expected bit = ^data for even, ~^data for odd.
  - On mismatch, `Parity_Error` = 1 from the cycle after the vote until the next frame start or reset.
  - Go to STOP at the bit end.
- **STOP**
  - Voted 0 → `Stop_Error` = 1, with the same hold rule as `Parity_Error`.
  - The voted decision is acted on in the cycle after the third sample, then go to DONE. The FSM does not wait for the stop-bit end, so back-to-back frames resync on the next falling edge.
- **DONE** (1 cycle)
  - If no errors: `P_DATA` ← shift register and `data_valid` = 1 for exactly this cycle.
  - If any error: `P_DATA` is unchanged and `data_valid` stays 0.
  - Go to IDLE.
- `P_DATA` holds its value until the next good frame.
- **Reset (RST = 0 at a CLK edge), including mid-frame**
  - State ← IDLE; counters ← 0; shift register ← 0.
  - `P_DATA` ← 0x00; `data_valid`, `Parity_Error`, `Stop_Error` ← 0.

## Timing
- All outputs are registered; all state changes happen at `CLK` rising edges.
- Reset takes effect at the first edge with `RST` = 0; the block is operational at the first edge with `RST` = 1.
- Frame length: (10 + PAR_EN) × Prescale cycles from start-bit detection.
- `data_valid` latency: rises 2 cycles after the edge at which the third stop sample is taken; width 1 cycle.
- Falling edge during DONE: ignored until IDLE the next cycle, which is still well before the start-bit mid-sample.
- Line tolerance: ±(P/2−2)/ (10P) of baud mismatch, for example ≥2% at P = 8.

## Structure
- Package `uart_rx_pkg`:
  - state enum (IDLE..DONE);
  - `PAR_EVEN` = 0, `PAR_ODD` = 1;
  - `DATA_W` = 8, `PRESCALE_W` = 6.
- Sub-module `uart_rx_sampler`:
  - contains the edge counter, the three-sample capture and the majority vote;
  - outputs `sample_valid`, `sampled_bit`, `bit_end`.
- The top level holds the FSM, bit counter, shift register, parity check and output registers.

## Test plan
- **Reset:** assert `RST` = 0 for 2 cycles mid-activity → `P_DATA` = 0x00 and all flags 0; release, then send 0xB2 → received correctly.
- **No parity:** send 0xB2 with `PAR_EN` = 0 and stop = 1, at P = 8, 16 and 32 → `P_DATA` = 0xB2, one-cycle `data_valid`, no errors.
- **Good parity:**
  - even, parity bit 0 → `data_valid`, `P_DATA` = 0xB2;
  - odd, parity bit 1 → same result.
- **Bad parity:** 0xB2 even with parity 1, and odd with parity 0 → `Parity_Error` = 1, no `data_valid`, `P_DATA` unchanged.
- **Bad stop:** 0xB2, no parity, stop = 0 → `Stop_Error` = 1, no `data_valid`.
- **Back-to-back:**
  - 0xB2 (even parity 0) then 0xA4 (even parity 1), no idle gap → two `data_valid` strobes with 0xB2 then 0xA4.
  - Odd-parity variant (parity bits 1/0) → same two strobes.
  - 0xA4 with a wrong parity bit → second frame flags `Parity_Error` only.
